// File: rtl/dcache_stall_ctrl.sv
// dcache_stall_ctrl: direct-mapped write-back/write-allocate D-cache with pipeline stall and line-wide memory handshake
module dcache_stall_ctrl #(
    parameter int LINES  = 16,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 5;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t            state;
    logic [LINES-1:0]  valid, dirty;
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [LINE_W-1:0] data_mem [LINES];
    logic [IDX_W-1:0]  idx, miss_idx;
    logic [TAG_W-1:0]  tag, miss_tag;
    logic [2:0]        off;
    logic [LINE_W-1:0] line;
    logic              hit, idle_hit, store_hit, fill;
    logic              unused_addr;

    assign idx         = cpu_addr_i[5 +: IDX_W];
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign off         = cpu_addr_i[4:2];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign line        = data_mem[idx];
    assign hit         = valid[idx] && tag_mem[idx] == tag;
    assign idle_hit    = state == IDLE && hit;
    assign store_hit   = cpu_req_i && cpu_write_i && idle_hit;
    assign fill        = state == ALLOCATE && mem_ack_i;
    assign cpu_stall_o = !rst_i && cpu_req_i && !idle_hit;
    assign cpu_rdata_o = (cpu_req_i && idle_hit) ? line[{off, 5'd0} +: 32] : '0;

    // Storage arrays are not reset; valid bits alone qualify their contents.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_mem[miss_idx] <= mem_rdata_i;
            tag_mem[miss_idx]  <= miss_tag;
        end else if (store_hit) begin
            data_mem[idx][{off, 5'd0} +: 32] <= cpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            miss_idx     <= '0;
            miss_tag     <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit)
                        dirty[idx] <= 1'b1;
                    if (cpu_req_i && !hit) begin
                        miss_idx     <= idx;
                        miss_tag     <= tag;
                        mem_enable_o <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_mem[idx], idx, 5'd0};
                            mem_wdata_o <= line;
                        end else begin
                            state       <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {tag, idx, 5'd0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state           <= ALLOCATE;
                        dirty[miss_idx] <= 1'b0;
                        mem_write_o     <= 1'b0;
                        mem_addr_o      <= {miss_tag, miss_idx, 5'd0};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state           <= IDLE;
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        mem_enable_o    <= 1'b0;
                        mem_write_o     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// tb_dcache_stall_ctrl: directed-vector bench for dcache_stall_ctrl
module tb_dcache_stall_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         stall;
    logic         men;
    logic         mwr;
    logic [31:0]  maddr;
    logic [255:0] mwdata;
    logic [255:0] mrd = '0;
    logic         ack = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    dcache_stall_ctrl dut (
        .clk_i(clk), .rst_i(rst), .cpu_req_i(req), .cpu_write_i(wr),
        .cpu_addr_i(addr), .cpu_wdata_i(wdata), .cpu_rdata_o(rdata),
        .cpu_stall_o(stall), .mem_enable_o(men), .mem_write_o(mwr),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_rdata_i(mrd),
        .mem_ack_i(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_en", 32'(men), 32'h0);
        check("rst_wr", 32'(mwr), 32'h0);
        check("rst_addr", maddr, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        tick(); req = 1'b1; addr = 32'h40;
        @(negedge clk);
        check("miss_stall_same_cycle", 32'(stall), 32'h1);
        check("miss_en_not_yet", 32'(men), 32'h0);
        tick();
        @(negedge clk);
        check("alloc_en", 32'(men), 32'h1);
        check("alloc_wr", 32'(mwr), 32'h0);
        check("alloc_addr", maddr, 32'h40);
        repeat (3) @(posedge clk);
        #1; ack = 1'b1; mrd = '0; mrd[31:0] = 32'h1234_5678; mrd[63:32] = 32'h1111_1111;
        @(negedge clk);
        check("alloc_stall_held", 32'(stall), 32'h1);
        tick(); ack = 1'b0;
        @(negedge clk);
        check("fill_stall", 32'(stall), 32'h0);
        check("fill_rdata", rdata, 32'h1234_5678);
        check("fill_en", 32'(men), 32'h0);
        tick(); wr = 1'b1; addr = 32'h44; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("store_hit_stall", 32'(stall), 32'h0);
        tick(); wr = 1'b0;
        @(negedge clk);
        check("load_after_store_stall", 32'(stall), 32'h0);
        check("load_after_store", rdata, 32'hDEAD_BEEF);
        tick(); addr = 32'h240;
        @(negedge clk);
        check("dirty_miss_stall", 32'(stall), 32'h1);
        tick();
        @(negedge clk);
        check("wb_en", 32'(men), 32'h1);
        check("wb_wr", 32'(mwr), 32'h1);
        check("wb_addr", maddr, 32'h40);
        check("wb_word1", mwdata[63:32], 32'hDEAD_BEEF);
        check("wb_word0", mwdata[31:0], 32'h1234_5678);
        check("wb_stall", 32'(stall), 32'h1);
        tick(); ack = 1'b1;
        @(negedge clk);
        check("wb_ack_stall", 32'(stall), 32'h1);
        tick(); ack = 1'b0; mrd = '0; mrd[31:0] = 32'hCAFE_0000;
        @(negedge clk);
        check("wb_alloc_en", 32'(men), 32'h1);
        check("wb_alloc_wr", 32'(mwr), 32'h0);
        check("wb_alloc_addr", maddr, 32'h240);
        check("wb_alloc_stall", 32'(stall), 32'h1);
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        @(negedge clk);
        check("refill_stall", 32'(stall), 32'h0);
        check("refill_rdata", rdata, 32'hCAFE_0000);
        tick(); addr = 32'h40;
        @(negedge clk);
        check("clean_miss_stall", 32'(stall), 32'h1);
        tick(); mrd = '0; mrd[31:0] = 32'h0BAD_F00D;
        @(negedge clk);
        check("clean_first_wr", 32'(mwr), 32'h0);
        check("clean_first_en", 32'(men), 32'h1);
        check("clean_first_addr", maddr, 32'h40);
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        @(negedge clk);
        check("clean_refill_rdata", rdata, 32'h0BAD_F00D);
        tick(); addr = 32'h80;
        @(negedge clk);
        check("rst_test_miss_stall", 32'(stall), 32'h1);
        tick();
        @(negedge clk);
        check("rst_test_alloc_en", 32'(men), 32'h1);
        tick(); rst = 1'b1;
        #1;
        check("async_rst_en", 32'(men), 32'h0);
        check("async_rst_stall", 32'(stall), 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        tick(); rst = 1'b0; addr = 32'h40;
        @(negedge clk);
        check("post_rst_miss", 32'(stall), 32'h1);
        check("post_rst_en_idle", 32'(men), 32'h0);
        tick(); mrd = '0; mrd[31:0] = 32'h5555_AAAA;
        @(negedge clk);
        check("post_rst_alloc_wr", 32'(mwr), 32'h0);
        check("post_rst_alloc_addr", maddr, 32'h40);
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        @(negedge clk);
        check("post_rst_refill", rdata, 32'h5555_AAAA);
        tick(); req = 1'b0; addr = 32'h300; ack = 1'b1;
        @(negedge clk);
        check("idle_noreq_stall", 32'(stall), 32'h0);
        check("idle_noreq_rdata", rdata, 32'h0);
        tick(); ack = 1'b0;
        @(negedge clk);
        check("spurious_ack_en", 32'(men), 32'h0);
        check("spurious_ack_stall", 32'(stall), 32'h0);
        tick(); req = 1'b1; addr = 32'h40;
        @(negedge clk);
        check("still_hit_stall", 32'(stall), 32'h0);
        check("still_hit_rdata", rdata, 32'h5555_AAAA);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
